// File: rtl/write_back_buffer.sv
// write_back_buffer: coalescing FIFO of evicted cache lines drained to memory.
// Ports:
//   clk, rst                  clock, async active-high reset
//   valid_i/addr_i/data_i     eviction offer; ready_o accepts it
//   lookup_i/lookup_tag_i     tag probe; hit_o/hit_data_o answer it
//   flush_i/flush_done_o      drain-to-empty request and completion pulse
//   mem_write_o/mem_addr_o/
//   mem_wdata_o/mem_resp_i    memory write channel (held until response)
//   count_o/empty_o/full_o    occupancy status
module write_back_buffer #(
    parameter int WIDTH    = 256,
    parameter int DEPTH    = 8,
    parameter int OFFSET   = 5,
    parameter int DRAIN_WM = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    input  logic [31:0]            addr_i,
    input  logic [WIDTH-1:0]       data_i,
    output logic                   ready_o,
    input  logic                   lookup_i,
    input  logic [31-OFFSET:0]     lookup_tag_i,
    output logic                   hit_o,
    output logic [WIDTH-1:0]       hit_data_o,
    input  logic                   flush_i,
    output logic                   flush_done_o,
    output logic                   mem_write_o,
    output logic [31:0]            mem_addr_o,
    output logic [WIDTH-1:0]       mem_wdata_o,
    input  logic                   mem_resp_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = 32 - OFFSET;

    typedef enum logic {
        S_IDLE,
        S_WRITE
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [DEPTH-1:0] vld;
    logic [TW-1:0]    tags  [DEPTH];
    logic [WIDTH-1:0] lines [DEPTH];

    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;

    logic             flush_pend;
    logic             flush_done;
    logic             pend_any;

    logic [TW-1:0]    in_tag;
    logic             coal_hit;
    logic [PW-1:0]    coal_idx;
    logic             look_hit;
    logic [PW-1:0]    look_idx;
    logic [PW-1:0]    scan;

    logic             enq;
    logic             coal;
    logic             deq;

    assign in_tag = addr_i[31:OFFSET];

    // Walk the live entries oldest to newest so the last match seen
    // is the newest one. The head is off-limits for coalescing while
    // it is being written, since its data must stay stable.
    always_comb begin
        coal_hit = 1'b0;
        coal_idx = head;
        look_hit = 1'b0;
        look_idx = head;
        scan     = head;
        for (int k = 0; k < DEPTH; k++) begin
            scan = head + PW'(k);
            if (vld[scan] && (tags[scan] == in_tag) &&
                !((state == S_WRITE) && (scan == head))) begin
                coal_hit = 1'b1;
                coal_idx = scan;
            end
            if (vld[scan] && (tags[scan] == lookup_tag_i)) begin
                look_hit = 1'b1;
                look_idx = scan;
            end
        end
    end

    assign count_o = count;
    assign empty_o = (count == '0);
    assign full_o  = (count == CW'(DEPTH));

    // A full buffer still absorbs a line it can merge in place.
    assign ready_o = !full_o || coal_hit;

    assign coal = valid_i && coal_hit;
    assign enq  = valid_i && !coal_hit && !full_o;

    assign hit_o      = lookup_i && look_hit;
    assign hit_data_o = hit_o ? lines[look_idx] : '0;

    assign count_nxt = count + CW'(enq) - CW'(deq);

    assign pend_any     = flush_pend || flush_i;
    assign flush_done_o = flush_done;

    always_comb begin
        state_nxt   = state;
        mem_write_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        deq         = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!empty_o &&
                    ((count >= CW'(DRAIN_WM)) || flush_pend)) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_write_o = 1'b1;
                mem_addr_o  = {tags[head], {OFFSET{1'b0}}};
                mem_wdata_o = lines[head];
                if (mem_resp_i) begin
                    deq       = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
        endcase
    end

    // Line storage carries no reset; the valid bits guard it.
    always_ff @(posedge clk) begin
        if (enq) begin
            tags[tail]  <= in_tag;
            lines[tail] <= data_i;
        end else if (coal) begin
            lines[coal_idx] <= data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            vld        <= '0;
            flush_pend <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (enq) begin
                vld[tail] <= 1'b1;
                tail      <= tail + PW'(1);
            end
            if (deq) begin
                vld[head] <= 1'b0;
                head      <= head + PW'(1);
            end
            // Completion lands on the edge that leaves the buffer empty,
            // so the pulse coincides with the first empty cycle.
            flush_done <= pend_any && (count_nxt == '0);
            flush_pend <= pend_any && (count_nxt != '0);
        end
    end

endmodule

// File: tb/tb_write_back_buffer.sv
// tb_write_back_buffer: directed and randomized checks of write_back_buffer
// against a queue-based reference model.
module tb_write_back_buffer;

    localparam int W   = 256;
    localparam int D   = 8;
    localparam int OFF = 5;
    localparam int WM  = 8;
    localparam int TW  = 32 - OFF;
    localparam int CW  = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_i;
    logic [31:0]   addr_i;
    logic [W-1:0]  data_i;
    logic          ready_o;
    logic          lookup_i;
    logic [TW-1:0] lookup_tag_i;
    logic          hit_o;
    logic [W-1:0]  hit_data_o;
    logic          flush_i;
    logic          flush_done_o;
    logic          mem_write_o;
    logic [31:0]   mem_addr_o;
    logic [W-1:0]  mem_wdata_o;
    logic          mem_resp_i;
    logic [CW-1:0] count_o;
    logic          empty_o;
    logic          full_o;

    logic          s_valid;
    logic [31:0]   s_addr;
    logic [31:0]   s_data;
    logic          s_ready;
    logic          s_hit;
    logic [31:0]   s_hit_data;
    logic          s_flush_done;
    logic          s_mem_write;
    logic [31:0]   s_mem_addr;
    logic [31:0]   s_mem_wdata;
    logic          s_resp;
    logic [2:0]    s_count;
    logic          s_empty;
    logic          s_full;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    write_back_buffer #(
        .WIDTH(W), .DEPTH(D), .OFFSET(OFF), .DRAIN_WM(WM)
    ) dut (
        .clk(clk), .rst(rst),
        .valid_i(valid_i), .addr_i(addr_i), .data_i(data_i),
        .ready_o(ready_o),
        .lookup_i(lookup_i), .lookup_tag_i(lookup_tag_i),
        .hit_o(hit_o), .hit_data_o(hit_data_o),
        .flush_i(flush_i), .flush_done_o(flush_done_o),
        .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_resp_i(mem_resp_i),
        .count_o(count_o), .empty_o(empty_o), .full_o(full_o)
    );

    write_back_buffer #(
        .WIDTH(32), .DEPTH(4), .OFFSET(OFF), .DRAIN_WM(1)
    ) dut_small (
        .clk(clk), .rst(rst),
        .valid_i(s_valid), .addr_i(s_addr), .data_i(s_data),
        .ready_o(s_ready),
        .lookup_i(1'b0), .lookup_tag_i('0),
        .hit_o(s_hit), .hit_data_o(s_hit_data),
        .flush_i(1'b0), .flush_done_o(s_flush_done),
        .mem_write_o(s_mem_write), .mem_addr_o(s_mem_addr),
        .mem_wdata_o(s_mem_wdata), .mem_resp_i(s_resp),
        .count_o(s_count), .empty_o(s_empty), .full_o(s_full)
    );

    // Reference model: queue of lines oldest-first plus drain/flush flags.
    typedef struct {
        logic [TW-1:0] tag;
        logic [W-1:0]  data;
    } ent_t;

    ent_t q[$];
    bit   m_wr;
    bit   m_pend;
    bit   m_done;

    logic [CW-1:0] e_count;
    logic          e_empty;
    logic          e_full;
    logic          e_ready;
    logic          e_hit;
    logic [W-1:0]  e_hdata;
    logic          e_mw;
    logic [31:0]   e_addr;
    logic [W-1:0]  e_wdata;
    logic          e_done;

    function automatic int find_newest(input logic [TW-1:0] t,
                                       input bit skip_head);
        int r = -1;
        for (int i = 0; i < q.size(); i++)
            if (q[i].tag == t && !(skip_head && i == 0)) r = i;
        return r;
    endfunction

    function automatic void model_eval();
        int j;
        int m;
        e_count = CW'(q.size());
        e_empty = (q.size() == 0);
        e_full  = (q.size() == D);
        m       = find_newest(addr_i[31:OFF], m_wr);
        e_ready = !e_full || (m >= 0);
        j       = find_newest(lookup_tag_i, 1'b0);
        e_hit   = lookup_i && (j >= 0);
        e_hdata = '0;
        if (e_hit) e_hdata = q[j].data;
        e_mw    = m_wr;
        e_addr  = 32'h0;
        e_wdata = '0;
        if (m_wr) begin
            e_addr  = {q[0].tag, 5'b0};
            e_wdata = q[0].data;
        end
        e_done  = m_done;
    endfunction

    task automatic model_tick();
        int   pre = q.size();
        bit   deq = m_wr && mem_resp_i;
        bit   pe  = m_pend || flush_i;
        int   j   = find_newest(addr_i[31:OFF], m_wr);
        bit   nwr;
        ent_t e;
        if (m_wr) nwr = !mem_resp_i;
        else      nwr = (pre > 0) && ((pre >= WM) || m_pend);
        if (valid_i && j >= 0) q[j].data = data_i;
        if (deq) void'(q.pop_front());
        if (valid_i && j < 0 && pre < D) begin
            e.tag  = addr_i[31:OFF];
            e.data = data_i;
            q.push_back(e);
        end
        m_wr   = nwr;
        m_done = pe && (q.size() == 0);
        m_pend = pe && (q.size() != 0);
    endtask

    function automatic logic [W-1:0] rand_line();
        logic [W-1:0] v;
        for (int b = 0; b < W / 32; b++) v[b*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic clear_inputs();
        valid_i      = 1'b0;
        addr_i       = '0;
        data_i       = '0;
        lookup_i     = 1'b0;
        lookup_tag_i = '0;
        flush_i      = 1'b0;
        mem_resp_i   = 1'b0;
        s_valid      = 1'b0;
        s_addr       = '0;
        s_data       = '0;
        s_resp       = 1'b0;
    endtask

    task automatic model_clear();
        q.delete();
        m_wr   = 1'b0;
        m_pend = 1'b0;
        m_done = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        lookup_i = 1'b1;
        rst = 1'b0;
        #1 rst = 1'b1;
        model_clear();
        for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            n_checks++;
            if (ready_o !== 1'b1) begin
                n_fails++;
                $display("FAIL reset_ready[%0d]: got %b expected 1", p, ready_o);
            end
            n_checks++;
            if (hit_o !== 1'b0) begin
                n_fails++;
                $display("FAIL reset_hit[%0d]: got %b expected 0", p, hit_o);
            end
            n_checks++;
            if (hit_data_o !== '0) begin
                n_fails++;
                $display("FAIL reset_hit_data[%0d]: got %h expected 0", p, hit_data_o);
            end
            n_checks++;
            if (flush_done_o !== 1'b0) begin
                n_fails++;
                $display("FAIL reset_flush_done[%0d]: got %b expected 0", p, flush_done_o);
            end
            n_checks++;
            if (mem_write_o !== 1'b0) begin
                n_fails++;
                $display("FAIL reset_mem_write[%0d]: got %b expected 0", p, mem_write_o);
            end
            n_checks++;
            if (mem_addr_o !== 32'h0) begin
                n_fails++;
                $display("FAIL reset_mem_addr[%0d]: got %h expected 0", p, mem_addr_o);
            end
            n_checks++;
            if (mem_wdata_o !== '0) begin
                n_fails++;
                $display("FAIL reset_mem_wdata[%0d]: got %h expected 0", p, mem_wdata_o);
            end
            n_checks++;
            if (count_o !== '0) begin
                n_fails++;
                $display("FAIL reset_count[%0d]: got %0d expected 0", p, count_o);
            end
            n_checks++;
            if (empty_o !== 1'b1) begin
                n_fails++;
                $display("FAIL reset_empty[%0d]: got %b expected 1", p, empty_o);
            end
            n_checks++;
            if (full_o !== 1'b0) begin
                n_fails++;
                $display("FAIL reset_full[%0d]: got %b expected 0", p, full_o);
            end
            rst = 1'b0;
        end
        lookup_i = 1'b0;
        #1;
    endtask

    task automatic test_full_backpressure();
        logic [W-1:0] d0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            valid_i = 1'b1;
            addr_i  = 32'h1000 + 32'(i) * 32;
            data_i  = rand_line();
            if (i == 0) d0 = data_i;
            @(negedge clk);
            n_checks++;
            if (ready_o !== 1'b1) begin
                n_fails++;
                $display("FAIL fill_ready[%0d]: got %b expected 1", i, ready_o);
            end
            step();
        end
        addr_i = 32'h2000;
        data_i = rand_line();
        @(negedge clk);
        n_checks++;
        if (full_o !== 1'b1) begin
            n_fails++;
            $display("FAIL full_flag: got %b expected 1", full_o);
        end
        n_checks++;
        if (ready_o !== 1'b0) begin
            n_fails++;
            $display("FAIL full_ready: got %b expected 0", ready_o);
        end
        n_checks++;
        if (mem_write_o !== 1'b0) begin
            n_fails++;
            $display("FAIL full_no_write_yet: got %b expected 0", mem_write_o);
        end
        step();
        valid_i      = 1'b0;
        lookup_i     = 1'b1;
        lookup_tag_i = TW'(32'h2000 >> OFF);
        @(negedge clk);
        n_checks++;
        if (mem_write_o !== 1'b1) begin
            n_fails++;
            $display("FAIL full_write_start: got %b expected 1", mem_write_o);
        end
        n_checks++;
        if (mem_addr_o !== 32'h1000) begin
            n_fails++;
            $display("FAIL full_write_addr: got %h expected 00001000", mem_addr_o);
        end
        n_checks++;
        if (mem_wdata_o !== d0) begin
            n_fails++;
            $display("FAIL full_write_data: got %h expected %h", mem_wdata_o, d0);
        end
        n_checks++;
        if (count_o !== 4'd8) begin
            n_fails++;
            $display("FAIL full_count: got %0d expected 8", count_o);
        end
        n_checks++;
        if (hit_o !== 1'b0) begin
            n_fails++;
            $display("FAIL full_rejected_absent: got %b expected 0", hit_o);
        end
    endtask

    task automatic test_coalesce();
        logic [W-1:0] da;
        logic [W-1:0] db;
        do_reset();
        da = rand_line();
        db = rand_line();
        valid_i = 1'b1;
        addr_i  = 32'h40;
        data_i  = da;
        step();
        addr_i = 32'h44;
        data_i = db;
        @(negedge clk);
        n_checks++;
        if (ready_o !== 1'b1) begin
            n_fails++;
            $display("FAIL coal_ready: got %b expected 1", ready_o);
        end
        step();
        valid_i      = 1'b0;
        lookup_i     = 1'b1;
        lookup_tag_i = TW'(2);
        @(negedge clk);
        n_checks++;
        if (count_o !== 4'd1) begin
            n_fails++;
            $display("FAIL coal_count: got %0d expected 1", count_o);
        end
        n_checks++;
        if (hit_o !== 1'b1) begin
            n_fails++;
            $display("FAIL coal_hit: got %b expected 1", hit_o);
        end
        n_checks++;
        if (hit_data_o !== db) begin
            n_fails++;
            $display("FAIL coal_hit_data: got %h expected %h", hit_data_o, db);
        end
        lookup_tag_i = TW'(3);
        #1;
        n_checks++;
        if (hit_o !== 1'b0 || hit_data_o !== '0) begin
            n_fails++;
            $display("FAIL lookup_miss: got %b/%h expected 0/0", hit_o, hit_data_o);
        end
        lookup_i     = 1'b0;
        lookup_tag_i = TW'(2);
        #1;
        n_checks++;
        if (hit_o !== 1'b0 || hit_data_o !== '0) begin
            n_fails++;
            $display("FAIL lookup_off: got %b/%h expected 0/0", hit_o, hit_data_o);
        end
    endtask

    task automatic test_head_in_write();
        logic [W-1:0] da;
        logic [W-1:0] dc;
        do_reset();
        da = rand_line();
        dc = rand_line();
        valid_i = 1'b1;
        addr_i  = 32'h40;
        data_i  = da;
        step();
        valid_i = 1'b0;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        step();
        valid_i = 1'b1;
        addr_i  = 32'h40;
        data_i  = dc;
        @(negedge clk);
        n_checks++;
        if (mem_write_o !== 1'b1 || ready_o !== 1'b1) begin
            n_fails++;
            $display("FAIL hw_write_ready: got %b/%b expected 1/1", mem_write_o, ready_o);
        end
        step();
        valid_i      = 1'b0;
        lookup_i     = 1'b1;
        lookup_tag_i = TW'(2);
        @(negedge clk);
        n_checks++;
        if (count_o !== 4'd2) begin
            n_fails++;
            $display("FAIL hw_count: got %0d expected 2", count_o);
        end
        n_checks++;
        if (mem_wdata_o !== da || mem_addr_o !== 32'h40) begin
            n_fails++;
            $display("FAIL hw_head_stable: got %h @%h expected %h @00000040", mem_wdata_o, mem_addr_o, da);
        end
        n_checks++;
        if (hit_o !== 1'b1 || hit_data_o !== dc) begin
            n_fails++;
            $display("FAIL hw_lookup_newest: got %b/%h expected 1/%h", hit_o, hit_data_o, dc);
        end
        lookup_i   = 1'b0;
        mem_resp_i = 1'b1;
        step();
        mem_resp_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_write_o !== 1'b0 || count_o !== 4'd1) begin
            n_fails++;
            $display("FAIL hw_idle_gap: got write=%b count=%0d expected 0/1", mem_write_o, count_o);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (mem_write_o !== 1'b1 || mem_wdata_o !== dc) begin
            n_fails++;
            $display("FAIL hw_second_write: got %b/%h expected 1/%h", mem_write_o, mem_wdata_o, dc);
        end
    endtask

    task automatic test_flush_order();
        logic [31:0]  xa [3];
        logic [W-1:0] xd [3];
        logic [31:0]  ga [3];
        logic [W-1:0] gd [3];
        int nw     = 0;
        int hold   = 0;
        int pulses = 0;
        bit bad_empty = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            xa[i]   = 32'h300 + 32'(i) * 32;
            xd[i]   = rand_line();
            valid_i = 1'b1;
            addr_i  = xa[i] | 32'(i + 1);
            data_i  = xd[i];
            step();
        end
        valid_i = 1'b0;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (flush_done_o) begin
                pulses++;
                if (!empty_o) bad_empty = 1'b1;
            end
            if (mem_write_o) begin
                if (hold == 0 && nw < 3) begin
                    ga[nw] = mem_addr_o;
                    gd[nw] = mem_wdata_o;
                    nw++;
                end
                mem_resp_i = (hold == 2);
                hold++;
            end else begin
                mem_resp_i = 1'b0;
                hold = 0;
            end
            step();
        end
        mem_resp_i = 1'b0;
        n_checks++;
        if (nw != 3) begin
            n_fails++;
            $display("FAIL flush_write_count: got %0d expected 3", nw);
        end
        for (int i = 0; i < nw; i++) begin
            n_checks++;
            if (ga[i] !== xa[i] || gd[i] !== xd[i]) begin
                n_fails++;
                $display("FAIL flush_order[%0d]: got %h expected %h", i, ga[i], xa[i]);
            end
        end
        n_checks++;
        if (pulses != 1) begin
            n_fails++;
            $display("FAIL flush_done_pulses: got %0d expected 1", pulses);
        end
        n_checks++;
        if (bad_empty) begin
            n_fails++;
            $display("FAIL flush_done_empty: got empty=0 at pulse expected 1");
        end
    endtask

    task automatic test_reset_mid_write();
        bit seen = 1'b0;
        do_reset();
        valid_i = 1'b1;
        addr_i  = 32'h7c0;
        data_i  = rand_line();
        step();
        valid_i = 1'b0;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (mem_write_o) seen = 1'b1;
            else step();
        end
        n_checks++;
        if (!seen) begin
            n_fails++;
            $display("FAIL rmw_timeout: got no write expected write within 10 cycles");
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (mem_write_o !== 1'b0 || count_o !== '0) begin
            n_fails++;
            $display("FAIL rmw_async: got write=%b count=%0d expected 0/0", mem_write_o, count_o);
        end
        n_checks++;
        if (empty_o !== 1'b1 || mem_addr_o !== 32'h0) begin
            n_fails++;
            $display("FAIL rmw_async_status: got empty=%b addr=%h expected 1/0", empty_o, mem_addr_o);
        end
        do_reset();
    endtask

    task automatic test_wrap();
        bit seen;
        logic [31:0] xa;
        logic [31:0] xd;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            xa      = 32'h500 + 32'(i) * 32;
            xd      = 32'hA5A5_0000 ^ 32'(i);
            s_valid = 1'b1;
            s_addr  = xa;
            s_data  = xd;
            step();
            s_valid = 1'b0;
            seen = 1'b0;
            for (int k = 0; k < 8 && !seen; k++) begin
                @(negedge clk);
                if (s_mem_write) begin
                    seen = 1'b1;
                    n_checks++;
                    if (s_mem_addr !== xa || s_mem_wdata !== xd) begin
                        n_fails++;
                        $display("FAIL wrap_write[%0d]: got %h/%h expected %h/%h", i, s_mem_addr, s_mem_wdata, xa, xd);
                    end
                    s_resp = 1'b1;
                    step();
                    s_resp = 1'b0;
                end else begin
                    step();
                end
            end
            n_checks++;
            if (!seen) begin
                n_fails++;
                $display("FAIL wrap_timeout[%0d]: got no write expected write", i);
            end
            @(negedge clk);
            n_checks++;
            if (s_count !== 3'd0 || s_empty !== 1'b1) begin
                n_fails++;
                $display("FAIL wrap_drained[%0d]: got count=%0d expected 0", i, s_count);
            end
        end
        #1;
    endtask

    task automatic test_random();
        int sel;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            valid_i      = ($urandom_range(0, 1) == 1);
            sel          = $urandom_range(0, 11);
            addr_i       = 32'h0100_0000 + 32'(sel) * 32 + 32'($urandom_range(0, 31));
            data_i       = rand_line();
            lookup_i     = ($urandom_range(0, 2) != 0);
            lookup_tag_i = TW'((32'h0100_0000 + 32'($urandom_range(0, 13)) * 32) >> OFF);
            flush_i      = ($urandom_range(0, 24) == 0);
            mem_resp_i   = ($urandom_range(0, 9) < 4);
            @(negedge clk);
            model_eval();
            n_checks++;
            if (count_o !== e_count) begin
                n_fails++;
                $display("FAIL rnd_count c=%0d: got %0d expected %0d", c, count_o, e_count);
            end
            n_checks++;
            if (empty_o !== e_empty || full_o !== e_full) begin
                n_fails++;
                $display("FAIL rnd_status c=%0d: got %b%b expected %b%b", c, empty_o, full_o, e_empty, e_full);
            end
            if (valid_i || !e_full) begin
                n_checks++;
                if (ready_o !== e_ready) begin
                    n_fails++;
                    $display("FAIL rnd_ready c=%0d: got %b expected %b", c, ready_o, e_ready);
                end
            end
            n_checks++;
            if (hit_o !== e_hit || hit_data_o !== e_hdata) begin
                n_fails++;
                $display("FAIL rnd_lookup c=%0d: got %b/%h expected %b/%h", c, hit_o, hit_data_o, e_hit, e_hdata);
            end
            n_checks++;
            if (mem_write_o !== e_mw || mem_addr_o !== e_addr) begin
                n_fails++;
                $display("FAIL rnd_mem c=%0d: got %b@%h expected %b@%h", c, mem_write_o, mem_addr_o, e_mw, e_addr);
            end
            n_checks++;
            if (mem_wdata_o !== e_wdata) begin
                n_fails++;
                $display("FAIL rnd_wdata c=%0d: got %h expected %h", c, mem_wdata_o, e_wdata);
            end
            n_checks++;
            if (flush_done_o !== e_done) begin
                n_fails++;
                $display("FAIL rnd_flush_done c=%0d: got %b expected %b", c, flush_done_o, e_done);
            end
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full_backpressure();
        test_coalesce();
        test_head_in_write();
        test_flush_order();
        test_reset_mid_write();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
